// File: rtl/fe_capture_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fe_capture_sequencer_if
// Purpose  : Control/status bundle between the capture sequencer and its
//            surroundings (arm/trigger, FIFO status, config, status outputs).
// Revision : 1.0 - initial release
// ============================================================================
interface fe_capture_sequencer_if #(
  parameter int pDELAY_WIDTH       = 16,
  parameter int pCAPTURE_LEN_WIDTH = 24,
  parameter int pSEG_WIDTH         = 8
);
  logic                          I_arm;
  logic                          I_trig;
  logic                          I_fifo_empty;
  logic                          I_fifo_full;
  logic [pDELAY_WIDTH-1:0]       I_trig_delay;
  logic [pCAPTURE_LEN_WIDTH-1:0] I_capture_cycles;
  logic [pSEG_WIDTH-1:0]         I_num_segments;
  logic [31:0]                   I_trig_timeout;
  logic                          O_capture_enable;
  logic                          O_flush_req;
  logic                          O_busy;
  logic                          O_done;
  logic                          O_overflow;
  logic                          O_timeout;
  logic [pSEG_WIDTH-1:0]         O_seg_count;
  logic [2:0]                    O_state;

  modport master (
    output I_arm, I_trig, I_fifo_empty, I_fifo_full,
    output I_trig_delay, I_capture_cycles, I_num_segments, I_trig_timeout,
    input  O_capture_enable, O_flush_req, O_busy, O_done,
    input  O_overflow, O_timeout, O_seg_count, O_state
  );

  modport slave (
    input  I_arm, I_trig, I_fifo_empty, I_fifo_full,
    input  I_trig_delay, I_capture_cycles, I_num_segments, I_trig_timeout,
    output O_capture_enable, O_flush_req, O_busy, O_done,
    output O_overflow, O_timeout, O_seg_count, O_state
  );
endinterface
`default_nettype wire

// File: rtl/fe_capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fe_capture_sequencer
// Purpose  : Arm -> flush -> trigger wait -> delay -> capture window sequencer,
//            repeated for N segments. FE_SEQ_TRIG_TIMEOUT_EN adds a trigger
//            wait timeout.
// Revision : 1.0 - initial release
// ============================================================================
module fe_capture_sequencer #(
  parameter int pDELAY_WIDTH       = 16,
  parameter int pCAPTURE_LEN_WIDTH = 24,
  parameter int pSEG_WIDTH         = 8
) (
  input wire                    fe_clk,
  input wire                    reset_i,
  fe_capture_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FLUSH     = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_DELAY     = 3'd3,
    S_CAPTURE   = 3'd4,
    S_DONE      = 3'd5
  } state_e;

  localparam logic [pDELAY_WIDTH-1:0]       c_DLY_ONE = pDELAY_WIDTH'(1);
  localparam logic [pCAPTURE_LEN_WIDTH-1:0] c_WIN_ONE = pCAPTURE_LEN_WIDTH'(1);
  localparam logic [pSEG_WIDTH-1:0]         c_SEG_ONE = pSEG_WIDTH'(1);

  state_e                        state_q, state_d;
  logic                          arm_q, trig_q;
  logic [pDELAY_WIDTH-1:0]       delay_cfg_q, delay_cfg_d, dly_cnt_q, dly_cnt_d;
  logic [pCAPTURE_LEN_WIDTH-1:0] cycles_cfg_q, cycles_cfg_d, win_cnt_q, win_cnt_d;
  logic [pSEG_WIDTH-1:0]         segs_cfg_q, segs_cfg_d, seg_cnt_q, seg_cnt_d;
  logic                          overflow_q, overflow_d;
  logic                          cap_en_q, flush_q, busy_q, done_q;
  logic                          w_trig_edge, w_win_last;
  logic [pSEG_WIDTH-1:0]         w_seg_next;
`ifdef FE_SEQ_TRIG_TIMEOUT_EN
  localparam logic [31:0] c_TO_ONE = 32'd1;
  logic [31:0] timeout_cfg_q, timeout_cfg_d, wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
`endif

  assign w_trig_edge = bus.I_trig & ~trig_q;
  assign w_seg_next  = (seg_cnt_q == '1) ? seg_cnt_q : seg_cnt_q + c_SEG_ONE;
  assign w_win_last  = (cycles_cfg_q != '0) && (win_cnt_q == cycles_cfg_q - c_WIN_ONE);

  always_comb begin
    state_d      = state_q;
    delay_cfg_d  = delay_cfg_q;
    cycles_cfg_d = cycles_cfg_q;
    segs_cfg_d   = segs_cfg_q;
    dly_cnt_d    = dly_cnt_q;
    win_cnt_d    = win_cnt_q;
    seg_cnt_d    = seg_cnt_q;
    overflow_d   = overflow_q;
`ifdef FE_SEQ_TRIG_TIMEOUT_EN
    timeout_cfg_d = timeout_cfg_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_d     = timeout_q;
`endif
    // Dropping arm aborts from any active state; flags and segment count hold.
    if (state_q != S_IDLE && !bus.I_arm) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.I_arm && !arm_q) begin
            state_d      = S_FLUSH;
            delay_cfg_d  = bus.I_trig_delay;
            cycles_cfg_d = bus.I_capture_cycles;
            segs_cfg_d   = (bus.I_num_segments == '0) ? c_SEG_ONE : bus.I_num_segments;
            seg_cnt_d    = '0;
            overflow_d   = 1'b0;
`ifdef FE_SEQ_TRIG_TIMEOUT_EN
            timeout_cfg_d = bus.I_trig_timeout;
            timeout_d     = 1'b0;
`endif
          end
        end
        S_FLUSH: begin
          if (bus.I_fifo_empty) state_d = S_WAIT_TRIG;
        end
        S_WAIT_TRIG: begin
          if (w_trig_edge) begin
            state_d = (delay_cfg_q != '0) ? S_DELAY : S_CAPTURE;
          end
`ifdef FE_SEQ_TRIG_TIMEOUT_EN
          else if (timeout_cfg_q != '0 && wait_cnt_q == timeout_cfg_q - c_TO_ONE) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
          end else if (wait_cnt_q != '1) begin
            wait_cnt_d = wait_cnt_q + c_TO_ONE;
          end
`endif
        end
        S_DELAY: begin
          if (dly_cnt_q == delay_cfg_q - c_DLY_ONE) state_d = S_CAPTURE;
          else if (dly_cnt_q != '1) dly_cnt_d = dly_cnt_q + c_DLY_ONE;
        end
        S_CAPTURE: begin
          if (win_cnt_q != '1) win_cnt_d = win_cnt_q + c_WIN_ONE;
          // FIFO full takes priority over a window that ends on count.
          if (bus.I_fifo_full) begin
            overflow_d = 1'b1;
            seg_cnt_d  = w_seg_next;
            state_d    = S_DONE;
          end else if (w_win_last) begin
            seg_cnt_d = w_seg_next;
            state_d   = (w_seg_next == segs_cfg_q) ? S_DONE : S_WAIT_TRIG;
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
    if (state_d != S_DELAY)   dly_cnt_d = '0;
    if (state_d != S_CAPTURE) win_cnt_d = '0;
`ifdef FE_SEQ_TRIG_TIMEOUT_EN
    if (state_d != S_WAIT_TRIG) wait_cnt_d = '0;
`endif
  end

  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      arm_q        <= 1'b0;
      trig_q       <= 1'b0;
      delay_cfg_q  <= '0;
      cycles_cfg_q <= '0;
      segs_cfg_q   <= '0;
      dly_cnt_q    <= '0;
      win_cnt_q    <= '0;
      seg_cnt_q    <= '0;
      overflow_q   <= 1'b0;
      cap_en_q     <= 1'b0;
      flush_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef FE_SEQ_TRIG_TIMEOUT_EN
      timeout_cfg_q <= '0;
      wait_cnt_q    <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      arm_q        <= bus.I_arm;
      trig_q       <= bus.I_trig;
      delay_cfg_q  <= delay_cfg_d;
      cycles_cfg_q <= cycles_cfg_d;
      segs_cfg_q   <= segs_cfg_d;
      dly_cnt_q    <= dly_cnt_d;
      win_cnt_q    <= win_cnt_d;
      seg_cnt_q    <= seg_cnt_d;
      overflow_q   <= overflow_d;
      cap_en_q     <= (state_d == S_CAPTURE);
      flush_q      <= (state_d == S_FLUSH);
      busy_q       <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q       <= (state_d == S_DONE);
`ifdef FE_SEQ_TRIG_TIMEOUT_EN
      timeout_cfg_q <= timeout_cfg_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

  assign bus.O_capture_enable = cap_en_q;
  assign bus.O_flush_req      = flush_q;
  assign bus.O_busy           = busy_q;
  assign bus.O_done           = done_q;
  assign bus.O_overflow       = overflow_q;
  assign bus.O_seg_count      = seg_cnt_q;
  assign bus.O_state          = state_q;
`ifdef FE_SEQ_TRIG_TIMEOUT_EN
  assign bus.O_timeout = timeout_q;
`else
  logic unused_trig_timeout;
  assign unused_trig_timeout = ^bus.I_trig_timeout;
  assign bus.O_timeout       = 1'b0;
`endif
endmodule
`default_nettype wire
